// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU codes, command opcodes.
// Pure declarations, no logic and no latency.
// No backpressure; consumers import this package.
package cpu_ctrl_pkg;

  // FSM state encodings (also exported on the debug state port)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing command field, funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Instruction class, instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  // ALU B-operand and result mux selects
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Immediate extender select follows the instruction class; undefined uses the DP form
  function automatic logic [1:0] imm_src_of(input logic [1:0] op);
    case (op)
      OP_MEM:  imm_src_of = 2'b01;
      OP_BR:   imm_src_of = 2'b10;
      default: imm_src_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields in, control enables out.
// No storage, no latency.
// No backpressure apart from mem_ready, which only matters in MEM_WAIT_EN builds.
interface multicycle_ctrl_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       mem_ready;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic [1:0] flag_w;
  logic       no_write;
  logic       ir_write;
  logic       next_pc;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [1:0] alu_control;
  logic [3:0] state;

  // Controller side
  modport master (
    input  op, funct, rd, mem_ready,
    output pcs, reg_w, mem_w, flag_w, no_write, ir_write, next_pc, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, reg_src, alu_control, state
  );

  // Datapath side
  modport slave (
    output op, funct, rd, mem_ready,
    input  pcs, reg_w, mem_w, flag_w, no_write, ir_write, next_pc, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, reg_src, alu_control, state
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Data-processing decode: funct[4:0] -> ALU op, flag write enables, CMP suppress, reg write.
// Purely combinational, zero latency.
// No backpressure; the FSM decides in which states these results are used.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write,
  output logic       reg_w_dp
);

  logic [3:0] cmd;
  logic       s_bit;
  logic       arith;
  logic       is_cmp;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  // Command lookup; unknown commands compute ADD but never write back
  always_comb begin
    alu_control = ALU_ADD;
    reg_w_dp    = 1'b0;
    arith       = 1'b0;
    is_cmp      = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_control = ALU_ADD; reg_w_dp = 1'b1; arith = 1'b1; end
      CMD_SUB: begin alu_control = ALU_SUB; reg_w_dp = 1'b1; arith = 1'b1; end
      CMD_AND: begin alu_control = ALU_AND; reg_w_dp = 1'b1; end
      CMD_ORR: begin alu_control = ALU_ORR; reg_w_dp = 1'b1; end
      CMD_CMP: begin alu_control = ALU_SUB; is_cmp = 1'b1; arith = 1'b1; end
      default: ;
    endcase
  end

  // NZ written when S is set, CV only for arithmetic; CMP always writes all flags
  assign flag_w   = is_cmp ? 2'b11 : {s_bit, s_bit & arith};
  assign no_write = is_cmp;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM (Moore) with ALU decoder; optional MEM_WAIT_EN memory stalls.
// Latency: DP 4, load 5, store 4, branch 3, undefined 2 cycles (plus stall cycles with MEM_WAIT_EN).
// With MEM_WAIT_EN, FETCH/MEMRD/MEMWR hold until mem_ready; otherwise mem_ready is ignored.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       hold;

  logic [1:0] dec_alu_control;
  logic [1:0] dec_flag_w;
  logic       dec_no_write;
  logic       dec_reg_w_dp;

  logic       ir_write;
  logic       next_pc;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] alu_control;
  logic       reg_w;
  logic       mem_w;
  logic       pcs;
  logic [1:0] flag_w;
  logic       no_write;

`ifdef MEM_WAIT_EN
  assign hold = ~bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign hold = 1'b0;
`endif

  alu_decoder u_alu_decoder (
    .funct       (bus.funct[4:0]),
    .alu_control (dec_alu_control),
    .flag_w      (dec_flag_w),
    .no_write    (dec_no_write),
    .reg_w_dp    (dec_reg_w_dp)
  );

  // State register; synchronous reset returns to FETCH, abandoning any instruction
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = hold ? S_FETCH : S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = bus.funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = hold ? S_MEMRD : S_MEMWB;
      S_MEMWR:  state_d = hold ? S_MEMWR : S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_MEMWB:  state_d = S_FETCH;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state, then reset override (strobes off, muxes at FETCH values)
  always_comb begin
    ir_write    = 1'b0;
    next_pc     = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    result_src  = RES_ALUOUT;
    alu_control = ALU_ADD;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    pcs         = 1'b0;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_MEMADR: alu_src_b = SRCB_IMM;
      S_MEMRD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b   = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
        alu_control = dec_alu_control;
        flag_w      = dec_flag_w;
        no_write    = dec_no_write;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_w      = dec_reg_w_dp;
        no_write   = dec_no_write;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pcs        = 1'b1;
      end
      default: ;
    endcase
    // A register write to R15 redirects the PC
    if ((state_q == S_MEMWB || state_q == S_ALUWB) && bus.rd == 4'hF && reg_w) pcs = 1'b1;
    if (reset) begin
      ir_write    = 1'b0;
      next_pc     = 1'b0;
      reg_w       = 1'b0;
      mem_w       = 1'b0;
      pcs         = 1'b0;
      flag_w      = 2'b00;
      no_write    = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 1'b1;
      alu_src_b   = SRCB_FOUR;
      result_src  = RES_ALU;
      alu_control = ALU_ADD;
    end
  end

  assign bus.ir_write    = ir_write;
  assign bus.next_pc     = next_pc;
  assign bus.adr_src     = adr_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.result_src  = result_src;
  assign bus.alu_control = alu_control;
  assign bus.reg_w       = reg_w;
  assign bus.mem_w       = mem_w;
  assign bus.pcs         = pcs;
  assign bus.flag_w      = flag_w;
  assign bus.no_write    = no_write;
  assign bus.imm_src     = imm_src_of(bus.op);
  assign bus.reg_src     = {bus.op == OP_MEM, bus.op == OP_BR};
  assign bus.state       = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: op  in  2  instr[27:26] from instruction register; funct  in  6  instr[25:20]; rd  in  4  instr[15:12].
REQ-004 SHALL have ports: mem_ready  in  1  memory access complete; used only under MEM_WAIT_EN.
REQ-005 SHALL have ports: pcs, reg_w, mem_w  out  1 each; flag_w  out  2; no_write  out  1. These are the raw enables for the downstream conditional-execution stage.
REQ-006 SHALL have ports: ir_write, next_pc, adr_src, alu_src_a  out  1 each; alu_src_b, result_src, imm_src, reg_src, alu_control  out  2 each.
REQ-007 SHALL have ports: state  out  4  current state, for debug.

Function
REQ-008 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-009 SHALL follow these transitions: FETCH->DECODE; DECODE->MEMADR (op=01), EXECI (op=00, funct[5]=1), EXECR (op=00, funct[5]=0), BRANCH (op=10), FETCH (op=11, undefined).
REQ-010 SHALL follow these transitions: MEMADR->MEMRD (funct[0]=1, load) else MEMWR; MEMRD->MEMWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH; EXECR, EXECI->ALUWB.
REQ-011 SHALL drive these outputs per state; any output not listed is 0:
- FETCH: ir_write=1, next_pc=1, adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10.
- MEMADR: alu_src_b=01.
- MEMRD: adr_src=1, result_src=00.
- MEMWR: adr_src=1, mem_w=1.
- MEMWB: result_src=01, reg_w=1.
- EXECR: alu_src_b=00.
- EXECI: alu_src_b=01.
- ALUWB: result_src=00, reg_w=reg_w_dp.
- BRANCH: alu_src_b=01, result_src=10, pcs=1.
REQ-012 SHALL assert pcs in MEMWB and ALUWB when rd=4'hF and reg_w=1.
REQ-013 SHALL decode alu_control in EXECR/EXECI from cmd=funct[4:1]: ADD 0100->00, SUB 0010->01, AND 0000->10, ORR 1100->11, CMP 1010->01. Any other cmd SHALL give 00 with reg_w_dp=0. In all other states alu_control SHALL be 00.
REQ-014 SHALL set flag_w in EXECR/EXECI to {S, S&(cmd is ADD|SUB|CMP)} with S=funct[0]. CMP SHALL force flag_w=11. flag_w SHALL be 00 elsewhere.
REQ-015 SHALL assert no_write=1 for CMP during EXECR/EXECI/ALUWB. For CMP, reg_w_dp SHALL be 0; for ADD/SUB/AND/ORR it SHALL be 1.
REQ-016 SHALL derive imm_src combinationally from op (00->00, 01->01, 10->10, 11->00). SHALL set reg_src={op==01, op==10}.
REQ-017 SHALL take latencies of 4 cycles for data-processing, 5 for load, 4 for store, 3 for branch, and 2 for undefined.

Reset
REQ-018 SHALL load state=FETCH on a clk edge with reset=1.
REQ-019 SHALL force ir_write, next_pc, reg_w, mem_w, pcs, flag_w and no_write to 0 combinationally while reset=1. Remaining outputs SHALL carry their FETCH values.
REQ-020 SHALL abandon any in-flight instruction on reset mid-operation, with no write strobe asserted in that cycle.

Configuration
REQ-021 SHALL, with MEM_WAIT_EN defined, hold FETCH, MEMRD and MEMWR while mem_ready=0. During the hold, ir_write, next_pc and mem_w SHALL stay asserted, and the state SHALL advance on the first edge with mem_ready=1.
REQ-022 SHALL, without MEM_WAIT_EN, ignore mem_ready and make every state last exactly one cycle.

Structure
REQ-023 SHALL place state encodings (4-bit localparams), alu_control codes and cmd opcodes in shared package cpu_ctrl_pkg.
REQ-024 SHALL split into the FSM plus one combinational sub-module alu_decoder (funct -> alu_control, flag_w, no_write, reg_w_dp).

Verification
REQ-025 SHALL verify ADD R1,R2,R3 with S=1 (op=00, funct=001001, rd=1): states FETCH,DECODE,EXECR,ALUWB; flag_w=11 in EXECR; reg_w=1 in ALUWB; pcs=0.
REQ-026 SHALL verify LDR R15 (op=01, funct=011001, rd=F): 5 states ending MEMWB with reg_w=1 and pcs=1.
REQ-027 SHALL verify STR (funct[0]=0): MEMWR with mem_w=1 and adr_src=1, then return to FETCH.
REQ-028 SHALL verify CMP (funct=010101): alu_control=01, flag_w=11, no_write=1, reg_w=0 in ALUWB.
REQ-029 SHALL verify reset asserted in MEMADR: next state FETCH and all strobes 0 during the reset cycle. Also op=11: DECODE->FETCH with no strobes.
REQ-030 SHALL verify, with MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH: state stays FETCH, ir_write stays 1, DECODE on the 4th edge.
